// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction fetch unit: FSM state encoding and
// the buffer entry layout used between the fetch control and its FIFO.
package instr_fetch_pkg;

    localparam logic [1:0] ST_BOOT  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_buffer.sv
// Two-entry instruction FIFO holding fetched words with their PCs.
// Clear wins over push/pop so a redirect drops everything in one edge.
module fetch_buffer
    import instr_fetch_pkg::*;
(
    input  logic         clk,
    input  logic         reset_n,
    input  logic         clear,
    input  logic         push,
    input  fetch_entry_t push_entry,
    input  logic         pop,
    output fetch_entry_t head,
    output logic [1:0]   count
);

    fetch_entry_t slots [2];
    logic         rd_ptr;
    logic         wr_ptr;
    logic         do_push;
    logic         do_pop;

    // A push into a full buffer is only legal when the head leaves on the same edge.
    assign do_push = push && ((count != 2'd2) || pop);
    assign do_pop  = pop && (count != 2'd0);
    assign head    = slots[rd_ptr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 2; i++) begin
                slots[i] <= '0;
            end
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (clear) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                slots[wr_ptr] <= push_entry;
                wr_ptr        <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: issues word reads, buffers returns in a 2-entry FIFO and
// handles jump/branch redirects by discarding whatever is still in flight.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        stall,
    input  logic        jb_enable,
    input  logic [31:0] jb_target_pc,
    output logic        imem_rd_en,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc
);

    logic [1:0]   state;
    logic [1:0]   state_next;
    logic [31:0]  fetch_pc;
    logic [31:0]  pending_pc;
    logic         pending;
    logic         discard;
    logic [1:0]   count;
    logic [2:0]   occupancy;
    logic         pop;
    logic         push;
    fetch_entry_t push_entry;
    fetch_entry_t head;

    assign inst_valid = (count != 2'd0);
    assign pop        = inst_valid & ~stall;

    // Reads already in flight count against free space so the FIFO never overflows.
    assign occupancy  = {1'b0, count} + {2'b00, pending} - {2'b00, pop};
    assign imem_rd_en = (state != ST_BOOT) && (occupancy < 3'(BUF_DEPTH));
    assign imem_addr  = fetch_pc;

    assign push       = pending & ~discard & ~jb_enable;
    assign push_entry = '{inst: imem_rdata, pc: pending_pc};

    always_comb begin
        state_next = state;
        case (state)
            ST_BOOT:  state_next = ST_RUN;
            ST_RUN:   state_next = jb_enable ? ST_FLUSH : ST_RUN;
            ST_FLUSH: state_next = jb_enable ? ST_FLUSH : ST_RUN;
            default:  state_next = ST_BOOT;
        endcase
    end

    // A read issued in the redirect cycle returns stale data, so it is tagged as discard.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_BOOT;
            fetch_pc   <= RESET_PC;
            pending_pc <= 32'h0;
            pending    <= 1'b0;
            discard    <= 1'b0;
        end else begin
            state      <= state_next;
            pending    <= imem_rd_en;
            discard    <= jb_enable & imem_rd_en;
            if (imem_rd_en) begin
                pending_pc <= fetch_pc;
            end
            if (jb_enable) begin
                fetch_pc <= jb_target_pc;
            end else if (imem_rd_en) begin
                fetch_pc <= fetch_pc + 32'd1;
            end
        end
    end

    fetch_buffer u_fetch_buffer (
        .clk        (clk),
        .reset_n    (reset_n),
        .clear      (jb_enable),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .head       (head),
        .count      (count)
    );

    assign inst    = head.inst;
    assign inst_pc = head.pc;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: a memory model returns addr*4 one cycle after
// each read, and a PC scoreboard checks every instruction consumed by decode.
module tb_instr_fetch;

    logic        clk;
    logic        reset_n;
    logic        stall;
    logic        jb_enable;
    logic [31:0] jb_target_pc;
    logic        imem_rd_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;

    int          total;
    int          bad;
    logic [31:0] expected_q[$];

    instr_fetch #(
        .RESET_PC  (32'h0),
        .BUF_DEPTH (2)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .stall        (stall),
        .jb_enable    (jb_enable),
        .jb_target_pc (jb_target_pc),
        .imem_rd_en   (imem_rd_en),
        .imem_addr    (imem_addr),
        .imem_rdata   (imem_rdata),
        .inst_valid   (inst_valid),
        .inst         (inst),
        .inst_pc      (inst_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory answers one cycle after a request; idle cycles return garbage.
    always @(posedge clk) begin
        if (imem_rd_en) begin
            imem_rdata <= imem_addr * 32'd4;
        end else begin
            imem_rdata <= 32'hDEADBEEF;
        end
    end

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Scores the instruction leaving at the coming edge, then moves to the next negedge.
    task automatic cycle();
        logic [31:0] e;
        if (reset_n && !jb_enable && !stall && inst_valid && (expected_q.size() > 0)) begin
            e = expected_q.pop_front();
            check_output("sb_pc", inst_pc, e);
            check_output("sb_inst", inst, e * 32'd4);
        end
        @(negedge clk);
    endtask

    task automatic drain(input string tag, input int budget);
        for (int i = 0; i < budget && expected_q.size() > 0; i++) begin
            cycle();
        end
        check_output(tag, 32'(expected_q.size()), 32'd0);
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        cycle();
        cycle();
        reset_n = 1'b1;
    endtask

    initial begin
        int          first;
        logic [31:0] ref_pc;
        bit          found;

        total        = 0;
        bad          = 0;
        reset_n      = 1'b0;
        stall        = 1'b0;
        jb_enable    = 1'b0;
        jb_target_pc = 32'h0;

        // Reset state and start-up latency
        cycle();
        cycle();
        check_output("rst_valid", 32'(inst_valid), 32'd0);
        check_output("rst_rd_en", 32'(imem_rd_en), 32'd0);
        check_output("rst_addr", imem_addr, 32'h0);
        check_output("rst_inst", inst, 32'h0);
        check_output("rst_inst_pc", inst_pc, 32'h0);
        for (int i = 0; i < 10; i++) expected_q.push_back(32'(i));
        reset_n = 1'b1;
        first = 0;
        for (int k = 1; k <= 12; k++) begin
            cycle();
            if (k == 1) begin
                check_output("first_rd_en", 32'(imem_rd_en), 32'd1);
                check_output("first_addr", imem_addr, 32'h0);
            end
            if (k == 2) check_output("second_addr", imem_addr, 32'h1);
            if (first == 0 && inst_valid) first = k;
        end
        check_output("first_valid_cycle", 32'(first), 32'd3);
        check_output("throughput_left", 32'(expected_q.size()), 32'd1);
        drain("drain_boot", 10);

        // Stall with a full buffer
        stall  = 1'b1;
        ref_pc = inst_pc;
        expected_q.delete();
        for (int i = 0; i < 8; i++) expected_q.push_back(ref_pc + 32'(i));
        for (int k = 0; k < 5; k++) begin
            cycle();
            check_output("stall_rd_en", 32'(imem_rd_en), 32'd0);
            check_output("stall_valid", 32'(inst_valid), 32'd1);
            check_output("stall_pc", inst_pc, ref_pc);
            check_output("stall_inst", inst, ref_pc * 32'd4);
        end
        stall = 1'b0;
        drain("drain_stall", 20);

        // Redirect to 0x40 while the read of PC 7 is in flight
        apply_reset();
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            cycle();
            if (imem_rd_en && imem_addr == 32'd7) found = 1'b1;
        end
        check_output("saw_pc7_read", 32'(found), 32'd1);
        cycle();
        jb_enable    = 1'b1;
        jb_target_pc = 32'h40;
        expected_q.delete();
        for (int i = 0; i < 6; i++) expected_q.push_back(32'h40 + 32'(i));
        cycle();
        jb_enable = 1'b0;
        check_output("flush_rd_en", 32'(imem_rd_en), 32'd1);
        check_output("flush_addr", imem_addr, 32'h40);
        check_output("flush_valid0", 32'(inst_valid), 32'd0);
        cycle();
        check_output("flush_valid1", 32'(inst_valid), 32'd0);
        cycle();
        check_output("flush_valid2", 32'(inst_valid), 32'd1);
        check_output("flush_first_pc", inst_pc, 32'h40);
        drain("drain_jump", 12);

        // Back-to-back redirects: only the last target survives
        jb_enable    = 1'b1;
        jb_target_pc = 32'h10;
        expected_q.delete();
        for (int i = 0; i < 6; i++) expected_q.push_back(32'h20 + 32'(i));
        cycle();
        check_output("double_addr1", imem_addr, 32'h10);
        jb_target_pc = 32'h20;
        cycle();
        jb_enable = 1'b0;
        check_output("double_addr2", imem_addr, 32'h20);
        cycle();
        cycle();
        check_output("double_valid", 32'(inst_valid), 32'd1);
        check_output("double_pc", inst_pc, 32'h20);
        drain("drain_double", 12);

        // PC wrap at the top of the address space
        jb_enable    = 1'b1;
        jb_target_pc = 32'hFFFFFFFF;
        expected_q.delete();
        expected_q.push_back(32'hFFFFFFFF);
        for (int i = 0; i < 3; i++) expected_q.push_back(32'(i));
        cycle();
        jb_enable = 1'b0;
        check_output("wrap_addr_top", imem_addr, 32'hFFFFFFFF);
        cycle();
        check_output("wrap_rd_en", 32'(imem_rd_en), 32'd1);
        check_output("wrap_addr_zero", imem_addr, 32'h0);
        drain("drain_wrap", 10);

        // Asynchronous reset with a full, stalled buffer
        stall = 1'b1;
        for (int k = 0; k < 4; k++) cycle();
        check_output("pre_rst_valid", 32'(inst_valid), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check_output("async_rst_valid", 32'(inst_valid), 32'd0);
        check_output("async_rst_rd_en", 32'(imem_rd_en), 32'd0);
        check_output("async_rst_addr", imem_addr, 32'h0);
        cycle();
        cycle();
        stall = 1'b0;
        expected_q.delete();
        for (int i = 0; i < 4; i++) expected_q.push_back(32'(i));
        reset_n = 1'b1;
        first = 0;
        for (int k = 1; k <= 6 && first == 0; k++) begin
            cycle();
            if (inst_valid) begin
                first = k;
                check_output("rerst_first_pc", inst_pc, 32'h0);
            end
        end
        check_output("rerst_valid_cycle", 32'(first), 32'd3);
        drain("drain_rerst", 10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0, word address of the first fetched instruction.
REQ-002 Parameter BUF_DEPTH, default 2, instruction buffer entries; only the value 2 is supported.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 reset_n  input  1  reset, asynchronous, active-low.
REQ-005 stall  input  1  decode not ready; head entry is held.
REQ-006 jb_enable  input  1  redirect request from jump_branch, one-cycle pulse.
REQ-007 jb_target_pc  input  32  word address of the redirect target.
REQ-008 imem_rd_en  output  1  instruction memory read request.
REQ-009 imem_addr  output  32  word address of the read request.
REQ-010 imem_rdata  input  32  read data, valid in the cycle after an accepted request.
REQ-011 inst_valid  output  1  the inst and inst_pc outputs hold a valid buffer head.
REQ-012 inst  output  32  instruction word at the buffer head.
REQ-013 inst_pc  output  32  word-address PC of the buffer head.

Function
REQ-014 The block SHALL implement the FSM states BOOT, RUN and FLUSH: BOOT->RUN unconditionally; RUN->FLUSH on jb_enable; FLUSH->RUN unless jb_enable, in which case it SHALL stay in FLUSH.
REQ-015 The block SHALL drive imem_rd_en combinationally in RUN and FLUSH when (count + pending - pop) < 2, where pop = inst_valid & ~stall; it SHALL never drive it in BOOT.
REQ-016 The block SHALL drive imem_addr = fetch_pc, and each issued read SHALL increment fetch_pc by 1 (word addressing, 32-bit wrap 32'hFFFFFFFF->0).
REQ-017 The block SHALL set pending for one cycle per issued read, capture imem_rdata with its PC into the buffer tail at the next edge, and raise inst_valid in the cycle after that capture (2 cycles from request to inst_valid).
REQ-018 The buffer SHALL be a 2-entry FIFO; simultaneous push and pop SHALL keep count unchanged and preserve order; count SHALL never exceed 2 or underflow.
REQ-019 Under stall, inst, inst_pc and inst_valid SHALL remain stable; with stall=0 the sustained throughput SHALL be 1 instruction per cycle.
REQ-020 On jb_enable at an edge, the block SHALL load fetch_pc with jb_target_pc, clear the buffer (inst_valid=0 next cycle), and mark any pending read as discard; discarded imem_rdata SHALL never enter the buffer.
REQ-021 In FLUSH the block SHALL issue jb_target_pc in the same cycle as the discarded return; the first target instruction SHALL reach inst_valid 2 cycles after FLUSH entry.
REQ-022 jb_enable SHALL override stall, and SHALL also be honoured in BOOT (the target replaces RESET_PC).
REQ-023 jb_enable in consecutive cycles SHALL make the last target win, with all earlier in-flight data discarded.

Reset
REQ-024 While reset_n=0 the block SHALL hold: state=BOOT, fetch_pc=RESET_PC, count=0, pending=0, discard=0, inst_valid=0, inst=0, inst_pc=0, imem_rd_en=0, imem_addr=RESET_PC.
REQ-025 Reset asserted mid-operation SHALL drop all buffered and in-flight data immediately; the first read after release SHALL be RESET_PC.

Structure
REQ-026 The FSM state encoding (BOOT, RUN, FLUSH) SHALL be defined in a shared include alongside instruction_param.vh; RESET_PC SHALL remain a module parameter.
REQ-027 The buffer SHALL be a sub-module named fetch_buffer (2-entry FIFO, push/pop/clear, count output).

Verification
REQ-028 The bench SHALL cover: reset release, stall=0, memory returning addr*4 -> reads at 0,1,2,...; inst_valid first in cycle 3; inst_pc 0,1,2 back-to-back.
REQ-029 The bench SHALL cover: stall held for 5 cycles with buffer full -> imem_rd_en=0, inst/inst_pc constant; after release, no PC skipped or duplicated.
REQ-030 The bench SHALL cover: jb_enable with target 0x40 while a read of PC 7 is in flight -> PC 7 never reaches inst_valid; next inst_pc=0x40, 2 cycles after FLUSH entry.
REQ-031 The bench SHALL cover: jb_enable pulses with targets 0x10 then 0x20 in consecutive cycles -> only the 0x20 stream appears.
REQ-032 The bench SHALL cover: fetch_pc=32'hFFFFFFFF -> next issued imem_addr=0.
REQ-033 The bench SHALL cover: reset_n asserted with 2 entries buffered and stall=1 -> inst_valid=0 asynchronously; after release the first inst_pc=RESET_PC.
